eth_rst_sequencer: RTL and testbench
====================================

# eth_rst_sequencer

Power-on reset sequencer for the Ethernet subsystem. It consumes the synchronized active-low reset produced by the upstream reset synchronizer and a PLL lock indication. It drives a timed reset pulse to the external PHY, waits a settle interval, then releases the MAC/UDP-IP datapath reset and asserts ready. It also supports a software-requested re-sequence and aborts the sequence on loss of PLL lock.

## Interface
Parameters:
- PHY_RST_CYCLES, default 1_000_000: cycles o_phy_rst_n is held low in S_PHY_RST (10 ms at 100 MHz); legal range ≥1.
- PHY_SETTLE_CYCLES, default 3_000_000: cycles between PHY release and MAC release; legal range ≥1.
- CNT_W, default $clog2(max(PHY_RST_CYCLES, PHY_SETTLE_CYCLES))+1: counter width, derived, not overridden.

Ports:
- i_clk  in  1  system clock; the block has one clock.
- i_reset  in  1  asynchronous, active-low reset; assertion is asynchronous.
- i_pll_locked  in  1  PLL lock, asynchronous to i_clk; synchronized internally.
- i_sw_rst  in  1  synchronous to i_clk; a one-cycle pulse requests a full PHY re-sequence.
- o_phy_rst_n  out  1  active-low reset to the PHY pin.
- o_mac_rst_n  out  1  active-low reset to the MAC and downstream datapath.
- o_ready  out  1  high only in S_RUN.
- o_state  out  2  current state encoding, for debug/status.

## Operation
- States and encodings: S_WAIT_LOCK=0, S_PHY_RST=1, S_PHY_SETTLE=2, S_RUN=3.
- Reset (i_reset=0) forces the following, asynchronously: state S_WAIT_LOCK, counter 0, synchronizer flops 0, o_phy_rst_n=0, o_mac_rst_n=0, o_ready=0, o_state=0.
- i_pll_locked passes through a 2-flop synchronizer to give lock_s.
- S_WAIT_LOCK: PHY and MAC held in reset. When lock_s=1, go to S_PHY_RST with counter 0.
- S_PHY_RST: o_phy_rst_n=0. The counter increments each cycle. At counter==PHY_RST_CYCLES-1, go to S_PHY_SETTLE and clear the counter.
- S_PHY_SETTLE: o_phy_rst_n=1, o_mac_rst_n=0. At counter==PHY_SETTLE_CYCLES-1, go to S_RUN.
- S_RUN: o_phy_rst_n=1, o_mac_rst_n=1, o_ready=1. The counter holds at 0.
- Abort and restart priority, evaluated every cycle (highest first):
  1. lock_s=0 in any state other than S_WAIT_LOCK: go to S_WAIT_LOCK.
  2. i_sw_rst=1 with lock_s=1: go to S_PHY_RST with counter 0. This applies in every state, including S_PHY_RST itself, where it restarts the count.
  3. Normal transitions listed above.
- i_sw_rst in S_WAIT_LOCK is ignored.
- All outputs are registered. Each output is computed from the next state, so it changes on the same edge as the state register and never glitches.

## Timing
- Outputs settle 1 edge after the state is decided; there is no combinational path from input to output.
- i_pll_locked rise to lock_s=1: 2 edges. The next edge enters S_PHY_RST.
- o_phy_rst_n is low for exactly PHY_RST_CYCLES edges within S_PHY_RST.
- o_phy_rst_n rise to o_mac_rst_n/o_ready rise: exactly PHY_SETTLE_CYCLES edges.
- Loss of lock: i_pll_locked fall → lock_s=0 after 2 edges. On the next edge, o_mac_rst_n, o_ready and o_phy_rst_n all go to 0.
- i_sw_rst sampled at edge N: o_phy_rst_n=0 and o_mac_rst_n=0 from edge N+1.
- Mid-sequence i_reset assertion: outputs go to reset values immediately, without waiting for a clock edge.

## Structure
- Shared package eth_pkg gets:
  - typedef enum logic [1:0] rst_seq_state_t with the four states above.
  - Default cycle constants ETH_PHY_RST_CYCLES and ETH_PHY_SETTLE_CYCLES.
- Sub-module sync_2ff: a 2-flop bit synchronizer with asynchronous active-low reset, instantiated for i_pll_locked.
- Top level: one counter plus one FSM. Parameter checks use an elaboration-time $error when either cycle parameter is <1.

## Test plan
All scenarios use PHY_RST_CYCLES=4 and PHY_SETTLE_CYCLES=6. Edges are counted from reset release.
- Power-up with lock already high: hold i_pll_locked=1 and release i_reset.
  - Edge 3: state=1.
  - Edge 7: o_phy_rst_n=1, state=2.
  - Edge 13: o_mac_rst_n=1, o_ready=1, state=3.
- Late lock: i_pll_locked rises 20 cycles after reset release → state stays 0 and all outputs stay 0 until 3 edges after the rise; then the same 4/6-cycle sequence follows.
- Lock loss in S_RUN: drop i_pll_locked → within 3 edges all outputs are 0 and state=0. Re-assert lock → the full sequence repeats.
- Software reset: pulse i_sw_rst in S_RUN → on the next edge o_phy_rst_n=0, o_mac_rst_n=0, state=1. Ready returns 10 edges later.
- Restart in S_PHY_RST: pulse i_sw_rst at counter=2 → o_phy_rst_n stays low for a further full 4 cycles. Also drive lock loss and i_sw_rst in the same cycle → lock loss wins and state goes to 0.
- Asynchronous reset mid-S_PHY_SETTLE: assert i_reset between clock edges → outputs are 0 before the next edge. Release → the sequence restarts from state 0.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared Ethernet subsystem definitions: reset sequencer state encoding and
// default PHY timing constants.
package eth_pkg;

    typedef enum logic [1:0] {
        S_WAIT_LOCK  = 2'd0,
        S_PHY_RST    = 2'd1,
        S_PHY_SETTLE = 2'd2,
        S_RUN        = 2'd3
    } rst_seq_state_t;

    // 10 ms and 30 ms at 100 MHz
    localparam int ETH_PHY_RST_CYCLES    = 1_000_000;
    localparam int ETH_PHY_SETTLE_CYCLES = 3_000_000;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop single-bit synchronizer with asynchronous active-low reset.
module sync_2ff (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_d,
    output logic o_q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= i_d;
            sync_q <= meta_q;
        end
    end

    assign o_q = sync_q;

endmodule

// File: rtl/eth_rst_sequencer.sv
// Power-on reset sequencer: waits for PLL lock, pulses the PHY reset, lets the PHY
// settle, then releases the MAC datapath. Restarts on software request or lock loss.
module eth_rst_sequencer
    import eth_pkg::*;
#(
    parameter int PHY_RST_CYCLES    = ETH_PHY_RST_CYCLES,
    parameter int PHY_SETTLE_CYCLES = ETH_PHY_SETTLE_CYCLES
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_pll_locked,
    input  logic       i_sw_rst,
    output logic       o_phy_rst_n,
    output logic       o_mac_rst_n,
    output logic       o_ready,
    output logic [1:0] o_state
);

    localparam int CNT_W = $clog2(max_int(PHY_RST_CYCLES, PHY_SETTLE_CYCLES)) + 1;

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PHY_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(PHY_SETTLE_CYCLES - 1);

    if (PHY_RST_CYCLES < 1) begin : g_chk_rst_cycles
        $error("eth_rst_sequencer: PHY_RST_CYCLES must be >= 1");
    end
    if (PHY_SETTLE_CYCLES < 1) begin : g_chk_settle_cycles
        $error("eth_rst_sequencer: PHY_SETTLE_CYCLES must be >= 1");
    end

    logic lock_s;

    sync_2ff u_lock_sync (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_d     (i_pll_locked),
        .o_q     (lock_s)
    );

    rst_seq_state_t   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             phy_rst_n_q, phy_rst_n_d;
    logic             mac_rst_n_q, mac_rst_n_d;
    logic             ready_q, ready_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;

        if (state_q != S_WAIT_LOCK && !lock_s) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
        end else if (i_sw_rst && lock_s && state_q != S_WAIT_LOCK) begin
            state_d = S_PHY_RST;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                S_WAIT_LOCK: begin
                    cnt_d = '0;
                    if (lock_s) begin
                        state_d = S_PHY_RST;
                    end
                end
                S_PHY_RST: begin
                    if (cnt_q == RST_LAST) begin
                        state_d = S_PHY_SETTLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_PHY_SETTLE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        state_d = S_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_RUN: begin
                    cnt_d = '0;
                end
            endcase
        end
    end

    // Outputs decode the next state so they flip on the same edge as state_q.
    always_comb begin
        phy_rst_n_d = (state_d == S_PHY_SETTLE) || (state_d == S_RUN);
        mac_rst_n_d = (state_d == S_RUN);
        ready_d     = (state_d == S_RUN);
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q     <= S_WAIT_LOCK;
            cnt_q       <= '0;
            phy_rst_n_q <= 1'b0;
            mac_rst_n_q <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            phy_rst_n_q <= phy_rst_n_d;
            mac_rst_n_q <= mac_rst_n_d;
            ready_q     <= ready_d;
        end
    end

    assign o_phy_rst_n = phy_rst_n_q;
    assign o_mac_rst_n = mac_rst_n_q;
    assign o_ready     = ready_q;
    assign o_state     = state_q;

endmodule

// File: tb/tb_eth_rst_sequencer.sv
// Scoreboard bench for eth_rst_sequencer with 4-cycle PHY reset and 6-cycle settle.
module tb_eth_rst_sequencer;

    // Expected {state[1:0], phy_rst_n, mac_rst_n, ready}
    localparam logic [4:0] V_OFF    = 5'b00000;
    localparam logic [4:0] V_PHYRST = 5'b01000;
    localparam logic [4:0] V_SETTLE = 5'b10100;
    localparam logic [4:0] V_RUN    = 5'b11111;

    typedef struct {
        int         cyc;
        logic [4:0] v;
        string      tag;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       pll_locked;
    logic       sw_rst;
    logic       phy_rst_n;
    logic       mac_rst_n;
    logic       ready;
    logic [1:0] state;

    int   cyc;
    int   n_cmp;
    int   n_err;
    exp_t sb[$];

    eth_rst_sequencer #(
        .PHY_RST_CYCLES    (4),
        .PHY_SETTLE_CYCLES (6)
    ) dut (
        .i_clk        (clk),
        .i_reset      (rst_n),
        .i_pll_locked (pll_locked),
        .i_sw_rst     (sw_rst),
        .o_phy_rst_n  (phy_rst_n),
        .o_mac_rst_n  (mac_rst_n),
        .o_ready      (ready),
        .o_state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %b, expected %b", tag, cyc, obs, exp);
        end
    endtask

    task automatic push(input int c, input logic [4:0] v, input string tag);
        exp_t e;
        e.cyc = c;
        e.v   = v;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            check_eq(e.tag, {27'd0, state, phy_rst_n, mac_rst_n, ready}, {27'd0, e.v});
        end
    end

    initial begin : stim
        int b;
        cyc        = 0;
        n_cmp      = 0;
        n_err      = 0;
        rst_n      = 1'b0;
        pll_locked = 1'b1;
        sw_rst     = 1'b0;

        // Power-up with lock already high
        wait_to(2);
        push(cyc, V_OFF, "reset_state");
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        b = cyc;
        push(b,      V_OFF,    "pu_release");
        push(b + 2,  V_OFF,    "pu_edge2_wait");
        push(b + 3,  V_PHYRST, "pu_edge3_phyrst");
        push(b + 6,  V_PHYRST, "pu_edge6_phyrst");
        push(b + 7,  V_SETTLE, "pu_edge7_settle");
        push(b + 12, V_SETTLE, "pu_edge12_settle");
        push(b + 13, V_RUN,    "pu_edge13_run");
        wait_to(b + 14);

        // Late lock, 20 cycles after reset release
        rst_n      = 1'b0;
        pll_locked = 1'b0;
        wait_to(cyc + 2);
        rst_n = 1'b1;
        b = cyc;
        push(b,      V_OFF,    "late_release");
        push(b + 19, V_OFF,    "late_nolock");
        push(b + 22, V_OFF,    "late_sync_lag");
        push(b + 23, V_PHYRST, "late_phyrst");
        push(b + 27, V_SETTLE, "late_settle");
        push(b + 33, V_RUN,    "late_run");
        wait_to(b + 20);
        pll_locked = 1'b1;
        wait_to(b + 35);

        // Lock loss in S_RUN, then relock
        b = cyc;
        pll_locked = 1'b0;
        push(b,      V_RUN,    "loss_run");
        push(b + 2,  V_RUN,    "loss_sync_lag");
        push(b + 3,  V_OFF,    "loss_abort");
        wait_to(b + 5);
        pll_locked = 1'b1;
        push(b + 7,  V_OFF,    "relock_lag");
        push(b + 8,  V_PHYRST, "relock_phyrst");
        push(b + 11, V_PHYRST, "relock_phyrst_end");
        push(b + 12, V_SETTLE, "relock_settle");
        push(b + 17, V_SETTLE, "relock_settle_end");
        push(b + 18, V_RUN,    "relock_run");
        wait_to(b + 19);

        // Software reset from S_RUN
        b = cyc;
        sw_rst = 1'b1;
        push(b,      V_RUN,    "sw_run");
        push(b + 1,  V_PHYRST, "sw_phyrst");
        push(b + 4,  V_PHYRST, "sw_phyrst_end");
        push(b + 5,  V_SETTLE, "sw_settle");
        push(b + 10, V_SETTLE, "sw_settle_end");
        push(b + 11, V_RUN,    "sw_ready_back");
        wait_to(b + 1);
        sw_rst = 1'b0;
        wait_to(b + 12);

        // Restart inside S_PHY_RST at counter 2
        sw_rst = 1'b1;
        wait_to(cyc + 1);
        sw_rst = 1'b0;
        b = cyc;
        wait_to(b + 2);
        sw_rst = 1'b1;
        push(b + 2,  V_PHYRST, "restart_cnt2");
        push(b + 4,  V_PHYRST, "restart_held");
        push(b + 6,  V_PHYRST, "restart_full4");
        push(b + 7,  V_SETTLE, "restart_settle");
        push(b + 12, V_SETTLE, "restart_settle_end");
        push(b + 13, V_RUN,    "restart_run");
        wait_to(b + 3);
        sw_rst = 1'b0;
        wait_to(b + 14);

        // Lock loss and sw reset seen in the same cycle: lock loss wins
        b = cyc;
        pll_locked = 1'b0;
        push(b,      V_RUN, "prio_run");
        push(b + 2,  V_RUN, "prio_sync_lag");
        push(b + 3,  V_OFF, "prio_lockloss_wins");
        push(b + 5,  V_OFF, "prio_sw_ignored");
        wait_to(b + 2);
        sw_rst = 1'b1;
        wait_to(b + 3);
        sw_rst = 1'b0;
        wait_to(b + 6);

        // Asynchronous reset mid-S_PHY_SETTLE
        b = cyc;
        pll_locked = 1'b1;
        push(b + 3, V_PHYRST, "async_phyrst");
        push(b + 8, V_SETTLE, "async_in_settle");
        wait_to(b + 9);
        push(b + 9,  V_OFF, "async_immediate");
        push(b + 10, V_OFF, "async_held");
        rst_n = 1'b0;
        wait_to(b + 11);
        rst_n = 1'b1;
        b = cyc;
        push(b,      V_OFF,    "async_release");
        push(b + 2,  V_OFF,    "async_edge2_wait");
        push(b + 3,  V_PHYRST, "async_edge3_phyrst");
        push(b + 7,  V_SETTLE, "async_edge7_settle");
        push(b + 13, V_RUN,    "async_edge13_run");
        wait_to(b + 15);

        check_eq("sb_drain", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
